// File: rtl/cnn_load_ctrl.sv
// rtl/cnn_load_ctrl.sv - load sequencer: memory reads to CNN combine-stage strobes
// Outputs are registered one cycle behind the state register, so each state's actions land on the following cycle.
module cnn_load_ctrl #(
    parameter int NUM_WORDS = 64,
    parameter int CNT_BW    = 16,
    parameter int RD_LAT    = 2,
    parameter int PIPE_DLY  = 4,
    parameter int FLUSH_CYC = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic              i_clear,
    input  logic [CNT_BW-1:0] i_base_addr,
    output logic              o_mem_rd_en,
    output logic [CNT_BW-1:0] o_mem_addr,
    output logic              o_f_enable,
    output logic [31:0]       o_f_address,
    output logic              o_f_value_done,
    output logic              o_f_done,
    output logic              o_busy
);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_FLUSH, S_DONE} state_t;

    localparam logic [CNT_BW-1:0] LAST_CNT   = CNT_BW'(NUM_WORDS - 1);
    localparam logic [7:0]        DRAIN_LAST = 8'(RD_LAT + PIPE_DLY - 1);
    localparam logic [7:0]        FLUSH_LAST = 8'(FLUSH_CYC - 1);

    state_t              r_state;
    logic [CNT_BW-1:0]   r_base;
    logic [CNT_BW-1:0]   r_cnt;
    logic [7:0]          r_dly;
    logic [RD_LAT-1:0]   r_vld_pipe;
    logic [CNT_BW-1:0]   r_idx_pipe [RD_LAT];
    logic                r_mem_rd_en;
    logic [CNT_BW-1:0]   r_mem_addr;
    logic                r_f_enable;
    logic [31:0]         r_f_address;
    logic                r_f_value_done;
    logic                r_f_done;
    logic                r_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_base         <= '0;
            r_cnt          <= '0;
            r_dly          <= '0;
            r_vld_pipe     <= '0;
            for (int i = 0; i < RD_LAT; i++) r_idx_pipe[i] <= '0;
            r_mem_rd_en    <= 1'b0;
            r_mem_addr     <= '0;
            r_f_enable     <= 1'b0;
            r_f_address    <= '0;
            r_f_value_done <= 1'b0;
            r_f_done       <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            // Index pipeline mirrors the memory read latency so the index lines up with its data word
            r_vld_pipe[0] <= 1'b0;
            for (int i = RD_LAT - 1; i > 0; i--) begin
                r_vld_pipe[i] <= r_vld_pipe[i-1];
                r_idx_pipe[i] <= r_idx_pipe[i-1];
            end
            if (r_vld_pipe[RD_LAT-1]) r_f_address <= 32'(r_idx_pipe[RD_LAT-1]);

            if (i_clear) begin
                r_state        <= S_IDLE;
                r_cnt          <= '0;
                r_dly          <= '0;
                r_vld_pipe     <= '0;
                r_mem_rd_en    <= 1'b0;
                r_mem_addr     <= '0;
                r_f_enable     <= 1'b0;
                r_f_address    <= '0;
                r_f_value_done <= 1'b0;
                r_f_done       <= 1'b0;
                r_busy         <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (i_start) begin
                            r_state        <= S_FETCH;
                            r_base         <= i_base_addr;
                            r_cnt          <= '0;
                            r_dly          <= '0;
                            r_vld_pipe     <= '0;
                            r_mem_rd_en    <= 1'b0;
                            r_f_enable     <= 1'b0;
                            r_f_address    <= '0;
                            r_f_value_done <= 1'b0;
                            r_f_done       <= 1'b0;
                            r_busy         <= 1'b0;
                        end else if (r_state == S_DONE) begin
                            r_mem_rd_en    <= 1'b0;
                            r_f_enable     <= 1'b0;
                            r_f_value_done <= 1'b1;
                            r_f_done       <= 1'b1;
                            r_busy         <= 1'b0;
                        end
                    end
                    S_FETCH: begin
                        r_mem_rd_en   <= 1'b1;
                        r_mem_addr    <= r_base + r_cnt;
                        r_f_enable    <= 1'b1;
                        r_busy        <= 1'b1;
                        r_vld_pipe[0] <= 1'b1;
                        r_idx_pipe[0] <= r_cnt;
                        r_cnt         <= r_cnt + 1'b1;
                        if (r_cnt == LAST_CNT) begin
                            r_state <= S_DRAIN;
                            r_dly   <= '0;
                        end
                    end
                    S_DRAIN: begin
                        r_mem_rd_en <= 1'b0;
                        if (r_dly == DRAIN_LAST) begin
                            r_state <= S_FLUSH;
                            r_dly   <= '0;
                        end else begin
                            r_dly <= r_dly + 8'd1;
                        end
                    end
                    S_FLUSH: begin
                        r_mem_rd_en    <= 1'b0;
                        r_f_value_done <= 1'b1;
                        if (r_dly == FLUSH_LAST) begin
                            r_state <= S_DONE;
                            r_dly   <= '0;
                        end else begin
                            r_dly <= r_dly + 8'd1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign o_mem_rd_en    = r_mem_rd_en;
    assign o_mem_addr     = r_mem_addr;
    assign o_f_enable     = r_f_enable;
    assign o_f_address    = r_f_address;
    assign o_f_value_done = r_f_value_done;
    assign o_f_done       = r_f_done;
    assign o_busy         = r_busy;

endmodule

// File: tb/tb_cnn_load_ctrl.sv
// tb/tb_cnn_load_ctrl.sv - scoreboard bench for cnn_load_ctrl
module tb_cnn_load_ctrl;

    localparam int PIPE = 4;
    localparam int FLSH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sel = 1'b0;
    logic        start0 = 1'b0, start1 = 1'b0, clear0 = 1'b0, clear1 = 1'b0;
    logic [15:0] base0 = '0, base1 = '0;

    logic        rd0, en0, vd0, dn0, bz0, rd1, en1, vd1, dn1, bz1;
    logic [15:0] ad0, ad1;
    logic [31:0] fa0, fa1;

    logic        o_rd, o_en, o_vd, o_dn, o_bz;
    logic [15:0] o_ad;
    logic [31:0] o_fa;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] q_addr [$];
    logic [31:0] q_idx  [$];

    always #5 clk = ~clk;

    cnn_load_ctrl u_dut0 (
        .clk(clk), .reset(reset), .i_start(start0), .i_clear(clear0), .i_base_addr(base0),
        .o_mem_rd_en(rd0), .o_mem_addr(ad0), .o_f_enable(en0), .o_f_address(fa0),
        .o_f_value_done(vd0), .o_f_done(dn0), .o_busy(bz0)
    );

    cnn_load_ctrl #(.NUM_WORDS(1), .CNT_BW(16), .RD_LAT(1), .PIPE_DLY(PIPE), .FLUSH_CYC(FLSH)) u_dut1 (
        .clk(clk), .reset(reset), .i_start(start1), .i_clear(clear1), .i_base_addr(base1),
        .o_mem_rd_en(rd1), .o_mem_addr(ad1), .o_f_enable(en1), .o_f_address(fa1),
        .o_f_value_done(vd1), .o_f_done(dn1), .o_busy(bz1)
    );

    always_comb begin
        o_rd = sel ? rd1 : rd0;
        o_en = sel ? en1 : en0;
        o_vd = sel ? vd1 : vd0;
        o_dn = sel ? dn1 : dn0;
        o_bz = sel ? bz1 : bz0;
        o_ad = sel ? ad1 : ad0;
        o_fa = sel ? fa1 : fa0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive_start(input logic v, input logic [15:0] b);
        if (sel) begin start1 = v; base1 = b; end
        else     begin start0 = v; base0 = b; end
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {o_rd, o_en, o_vd, o_dn, o_bz, o_ad != 16'd0, o_fa != 32'd0}, 32'd0);
    endtask

    task automatic run_load(input int n, input int rl, input logic [15:0] base, input bit noise);
        int last_k;
        logic [15:0] a;
        logic [31:0] ei;
        last_k = n + rl + PIPE + FLSH + 2;
        q_addr.delete();
        q_idx.delete();
        for (int i = 0; i < n; i++) begin
            a = base + 16'(i);
            q_addr.push_back(a);
            q_idx.push_back(32'(i));
        end
        @(negedge clk);
        drive_start(1'b1, base);
        for (int k = 0; k <= last_k; k++) begin
            @(negedge clk);
            drive_start(1'b0, base);
            check("rd_en", 32'(o_rd), 32'(k >= 1 && k <= n));
            check("f_enable", 32'(o_en), 32'(k >= 1 && k <= n + rl + PIPE + FLSH));
            check("value_done", 32'(o_vd), 32'(k >= n + rl + PIPE + 1));
            check("f_done", 32'(o_dn), 32'(k >= n + rl + PIPE + FLSH + 1));
            check("rd_vd_excl", 32'(o_rd & o_vd), 32'd0);
            if (k >= 1) check("busy", 32'(o_bz), 32'(k <= n + rl + PIPE + FLSH));
            if (o_rd) begin
                if (q_addr.size() == 0) check("extra_read", 32'd1, 32'd0);
                else begin
                    a = q_addr.pop_front();
                    check("mem_addr", 32'(o_ad), 32'(a));
                end
            end
            if (k - 1 - rl >= 0 && k - 1 - rl < n) begin
                ei = q_idx.pop_front();
                check("f_address", o_fa, ei);
            end
            if (noise && (k == 10 || k == n + 3 || k == n + rl + PIPE + 1))
                drive_start(1'b1, 16'h5555);
        end
        check("f_address_hold", o_fa, 32'(n - 1));
        check("addr_q_empty", 32'(q_addr.size()), 32'd0);
    endtask

    initial begin
        #2;
        check_all_zero("reset_state");
        @(negedge clk);
        reset = 1'b0;

        // Reset mid-fetch, then restart from the base
        @(negedge clk);
        start0 = 1'b1; base0 = 16'h0300;
        for (int k = 0; k <= 11; k++) begin
            @(negedge clk);
            start0 = 1'b0;
        end
        check("pre_reset_addr", 32'(o_ad), 32'h030A);
        #2 reset = 1'b1;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        reset = 1'b0;
        run_load(64, 2, 16'h0300, 1'b0);

        run_load(64, 2, 16'h0100, 1'b0);
        run_load(64, 2, 16'hFFF0, 1'b0);
        run_load(64, 2, 16'h0100, 1'b1);

        // Clear beats start while in DONE
        @(negedge clk);
        clear0 = 1'b1; start0 = 1'b1; base0 = 16'h0700;
        @(negedge clk);
        clear0 = 1'b0; start0 = 1'b0;
        check_all_zero("clear_over_start");
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("idle_no_read", 32'({o_rd, o_bz, o_en}), 32'd0);
        end

        sel = 1'b1;
        #1 check_all_zero("small_idle");
        run_load(1, 1, 16'hFFFF, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
